// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Each grant runs IDLE -> ACCESS -> RESP: one memory cycle, then a one-cycle ack.
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  output logic        p0_stall,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_data_read
);

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rr_last;
  logic        r_win;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;

  logic        w_any_req;
  logic        w_win;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_access;
  logic        w_mem_rd;

  // w_win: 0 = port 0, 1 = port 1; a lone requester always wins
  always_comb begin
    w_any_req = p0_req | p1_req;
    w_win     = ~p0_req;
    if (RR_EN && p0_req && p1_req)
      w_win = ~r_rr_last;
    w_sel_we    = w_win ? p1_we    : p0_we;
    w_sel_addr  = w_win ? p1_addr  : p0_addr;
    w_sel_wdata = w_win ? p1_wdata : p0_wdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Out-of-range accesses keep every memory strobe low
  assign w_access = (r_state == ACCESS) & ~r_err;
  assign w_mem_rd = w_access & ~r_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last  <= 1'b1;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_win     <= w_win;
        r_rr_last <= w_win;
        r_we      <= w_sel_we;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_err     <= (w_sel_addr >= LP_DEPTH);
      end
      if (w_mem_rd) begin
        if (r_win)
          r_p1_rdata <= mem_data_read;
        else
          r_p0_rdata <= mem_data_read;
      end
    end
  end

  assign mem_write      = w_access & r_we;
  assign mem_read       = w_mem_rd;
  assign mem_address    = w_access ? r_addr  : '0;
  assign mem_write_data = w_access ? r_wdata : '0;

  assign p0_ack   = (r_state == RESP) & ~r_win;
  assign p1_ack   = (r_state == RESP) &  r_win;
  assign p0_err   = p0_ack & r_err;
  assign p1_err   = p1_ack & r_err;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;
  assign p0_stall = p0_req & ~p0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share the
// same request stimulus, each checked cycle by cycle against a transaction model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic        d_p0_ack [2], d_p0_err [2], d_p0_stall [2];
  logic        d_p1_ack [2], d_p1_err [2];
  logic        d_mem_write [2], d_mem_read [2];
  logic [31:0] d_p0_rdata [2], d_p1_rdata [2];
  logic [31:0] d_mem_address [2], d_mem_write_data [2], d_mem_data_read [2];
  logic [31:0] phys [2][1024];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(d_p0_ack[0]), .p0_rdata(d_p0_rdata[0]), .p0_err(d_p0_err[0]), .p0_stall(d_p0_stall[0]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(d_p1_ack[0]), .p1_rdata(d_p1_rdata[0]), .p1_err(d_p1_err[0]),
    .mem_write(d_mem_write[0]), .mem_read(d_mem_read[0]), .mem_address(d_mem_address[0]),
    .mem_write_data(d_mem_write_data[0]), .mem_data_read(d_mem_data_read[0])
  );

  dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b0)) u_fixed (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(d_p0_ack[1]), .p0_rdata(d_p0_rdata[1]), .p0_err(d_p0_err[1]), .p0_stall(d_p0_stall[1]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(d_p1_ack[1]), .p1_rdata(d_p1_rdata[1]), .p1_err(d_p1_err[1]),
    .mem_write(d_mem_write[1]), .mem_read(d_mem_read[1]), .mem_address(d_mem_address[1]),
    .mem_write_data(d_mem_write_data[1]), .mem_data_read(d_mem_data_read[1])
  );

  // Data memories attached to the two instances (cleared by reset)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 1024; i++)
          phys[k][i] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (d_mem_write[k] && d_mem_address[k] < 32'd1024)
          phys[k][d_mem_address[k][9:0]] <= d_mem_write_data[k];
    end
  end

  assign d_mem_data_read[0] = (d_mem_read[0] && d_mem_address[0] < 32'd1024) ?
                              phys[0][d_mem_address[0][9:0]] : 32'h0;
  assign d_mem_data_read[1] = (d_mem_read[1] && d_mem_address[1] < 32'd1024) ?
                              phys[1][d_mem_address[1][9:0]] : 32'h0;

  // Reference model: m_left counts the cycles left in the current grant
  // (2 = memory cycle next, 1 = ack cycle next, 0 = free to arbitrate)
  int          m_left [2];
  bit          m_win [2], m_we [2], m_err [2], m_rr_last [2];
  logic [31:0] m_addr [2], m_wdata [2];
  logic [31:0] m_rd [2][2];
  logic [31:0] m_mem [2][1024];

  bit          obs_ack [2][2];
  bit          obs_err [2][2];
  logic [31:0] obs_rd [2][2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_win[k] = 0; m_we[k] = 0; m_err[k] = 0; m_rr_last[k] = 1;
      m_addr[k] = '0; m_wdata[k] = '0; m_rd[k][0] = '0; m_rd[k][1] = '0;
      for (int i = 0; i < 1024; i++) m_mem[k][i] = '0;
    end
  endfunction

  function automatic bit pick_winner(int k);
    if (p0_req && p1_req) return (k == 0) ? !m_rr_last[k] : 1'b0;
    return !p0_req;
  endfunction

  function automatic void model_step();
    bit w;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_left[k] == 2) begin
        if (!m_err[k]) begin
          if (m_we[k]) m_mem[k][m_addr[k][9:0]] = m_wdata[k];
          else         m_rd[k][m_win[k]] = m_mem[k][m_addr[k][9:0]];
        end
        m_left[k] = 1;
      end else if (m_left[k] == 1) begin
        m_left[k] = 0;
      end else if (p0_req || p1_req) begin
        w = pick_winner(k);
        m_win[k] = w; m_rr_last[k] = w;
        m_we[k]    = w ? p1_we    : p0_we;
        m_addr[k]  = w ? p1_addr  : p0_addr;
        m_wdata[k] = w ? p1_wdata : p0_wdata;
        m_err[k]   = (m_addr[k] >= 32'd1024);
        m_left[k]  = 2;
      end
    end
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      bit acc = (m_left[k] == 2) && !m_err[k];
      bit e0  = (m_left[k] == 1) && !m_win[k];
      bit e1  = (m_left[k] == 1) &&  m_win[k];
      chk("mem_write", k, d_mem_write[k], acc && m_we[k]);
      chk("mem_read", k, d_mem_read[k], acc && !m_we[k]);
      if (acc) begin
        chk("mem_address", k, d_mem_address[k], m_addr[k]);
        if (m_we[k]) chk("mem_write_data", k, d_mem_write_data[k], m_wdata[k]);
      end
      chk("p0_ack", k, d_p0_ack[k], e0);
      chk("p1_ack", k, d_p1_ack[k], e1);
      if (e0) chk("p0_err", k, d_p0_err[k], m_err[k]);
      if (e1) chk("p1_err", k, d_p1_err[k], m_err[k]);
      chk("p0_rdata", k, d_p0_rdata[k], m_rd[k][0]);
      chk("p1_rdata", k, d_p1_rdata[k], m_rd[k][1]);
      chk("p0_stall", k, d_p0_stall[k], p0_req && !e0);
      obs_ack[k][0] = d_p0_ack[k]; obs_ack[k][1] = d_p1_ack[k];
      obs_err[k][0] = d_p0_err[k]; obs_err[k][1] = d_p1_err[k];
      obs_rd[k][0]  = d_p0_rdata[k]; obs_rd[k][1] = d_p1_rdata[k];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (p == 0) begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    else        begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
  endtask

  task automatic run_until_ack(input int p, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n++;
      if (obs_ack[0][p]) break;
    end
    if (!obs_ack[0][p]) chk("ack_timeout", p, obs_ack[0][p], 1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd1024;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1023;
      3:       return $urandom;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, last, g;
    logic [31:0] keep;
    bit pend [2];

    // reset
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // write then read back address 5
    drive(0, 1, 1, 32'd5, 32'hDEAD_BEEF);
    run_until_ack(0, n);
    chk("wr_latency", 0, n, 3);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 32'd5, 32'h0);
    run_until_ack(0, n);
    chk("rd_latency", 0, n, 3);
    chk("rd5_data", 0, obs_rd[0][0], 32'hDEAD_BEEF);
    chk("rd5_err", 0, obs_err[0][0], 0);
    drive(0, 0, 0, 0, 0);

    // both ports hold requests continuously
    drive(0, 1, 1, 32'd7, 32'h1111_0000);
    drive(1, 1, 0, 32'd7, 32'h0);
    acks = 0; last = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_ack[0][0] || obs_ack[0][1]) begin
        g = obs_ack[0][1] ? 1 : 0;
        if (last >= 0) chk("rr_alternate", 0, g, (last == 0) ? 1 : 0);
        last = g;
        acks++;
      end
      chk("fixed_no_p1_ack", 1, obs_ack[1][1], 0);
    end
    chk("rr_ack_count", 0, acks, 4);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    cycle();
    cycle();

    // out-of-range reads on port 1, plus the last legal address
    keep = m_rd[0][1];
    drive(1, 1, 0, 32'd1024, 0);
    run_until_ack(1, n);
    chk("oor1024_err", 0, obs_err[0][1], 1);
    chk("oor1024_rdata", 0, obs_rd[0][1], keep);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 32'hFFFF_FFFF, 0);
    run_until_ack(1, n);
    chk("oormax_err", 0, obs_err[0][1], 1);
    chk("oormax_rdata", 0, obs_rd[0][1], keep);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 32'd1023, 0);
    run_until_ack(1, n);
    chk("addr1023_err", 0, obs_err[0][1], 0);
    drive(1, 0, 0, 0, 0);

    // reset while a port 0 write is in its memory cycle
    drive(0, 1, 1, 32'd5, 32'h1234_5678);
    cycle();
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0);
    cycle();
    chk("rst_mem_write", 0, d_mem_write[0], 0);
    chk("rst_p0_ack", 0, obs_ack[0][0], 0);
    reset = 1'b0;
    cycle();
    drive(0, 1, 0, 32'd5, 0);
    run_until_ack(0, n);
    chk("post_rst_rd5", 0, obs_rd[0][0], 32'h0);
    drive(0, 0, 0, 0, 0);

    // request withdrawn right after the grant
    drive(0, 1, 1, 32'd9, 32'h0BAD_F00D);
    cycle();
    drive(0, 0, 0, 0, 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_ack[0][0]) acks++;
    end
    chk("drop_ack_count", 0, acks, 1);

    // randomized traffic
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && obs_ack[0][p]) begin
          pend[p] = 0;
          drive(p, 0, 0, 0, 0);
        end else if (pend[p] && $urandom_range(0, 39) == 0) begin
          pend[p] = 0;
          drive(p, 0, 0, 0, 0);
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          drive(p, 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
